// File: rtl/bsg_two_fifo_width_p3.sv
// Two-entry valid/ready -> valid/yumi FIFO for a 3-bit control field.
// Define BSG_TWO_FIFO_BYPASS_EN to let an empty FIFO present data_i combinationally.
module bsg_two_fifo_width_p3 #(
  parameter int width_p = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  input  logic               yumi_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] mem_r [2];
  logic               rptr_r, wptr_r;
  logic               empty_r, full_r;
  logic               rptr_n_s, wptr_n_s;
  logic               empty_n_s, full_n_s;
  logic               enq_s, deq_s, bypass_s;

  assign ready_o = ~full_r;

  // Event decode; a yumi against an empty FIFO is ignored so state stays intact.
  always_comb begin
    enq_s    = v_i & ~full_r;
    deq_s    = yumi_i & ~empty_r;
`ifdef BSG_TWO_FIFO_BYPASS_EN
    bypass_s = empty_r & v_i & yumi_i;
`else
    bypass_s = 1'b0;
`endif
    if (bypass_s) begin
      enq_s = 1'b0;
    end else begin
      enq_s = enq_s;
    end
  end

  // Next pointer and occupancy flags.
  always_comb begin
    rptr_n_s  = rptr_r;
    wptr_n_s  = wptr_r;
    empty_n_s = empty_r;
    full_n_s  = full_r;
    if (reset_i) begin
      rptr_n_s  = 1'b0;
      wptr_n_s  = 1'b0;
      empty_n_s = 1'b1;
      full_n_s  = 1'b0;
    end else begin
      if (enq_s) begin
        wptr_n_s = ~wptr_r;
      end else begin
        wptr_n_s = wptr_r;
      end
      if (deq_s) begin
        rptr_n_s = ~rptr_r;
      end else begin
        rptr_n_s = rptr_r;
      end
      if (enq_s & ~deq_s) begin
        empty_n_s = 1'b0;
        full_n_s  = ~empty_r;
      end else if (deq_s & ~enq_s) begin
        full_n_s  = 1'b0;
        empty_n_s = ~full_r;
      end else begin
        empty_n_s = empty_r;
        full_n_s  = full_r;
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk_i) begin
    rptr_r  <= rptr_n_s;
    wptr_r  <= wptr_n_s;
    empty_r <= empty_n_s;
    full_r  <= full_n_s;
  end

  // Storage is write-enabled only; its contents need no reset because flags gate visibility.
  always_ff @(posedge clk_i) begin
    if (enq_s) begin
      mem_r[wptr_r] <= data_i;
    end
  end

  // Head presentation.
  always_comb begin
    v_o    = ~empty_r;
    data_o = mem_r[rptr_r];
`ifdef BSG_TWO_FIFO_BYPASS_EN
    if (empty_r & v_i) begin
      v_o    = 1'b1;
      data_o = data_i;
    end else begin
      v_o    = ~empty_r;
      data_o = mem_r[rptr_r];
    end
`endif
  end

endmodule
